tick_stop_gen: RTL and testbench



---
 rtl/tick_stop_gen.sv | 54 +++++
 tb/tb_tick_stop_gen.sv | 77 +++++++
 2 files changed

// File: rtl/tick_stop_gen.sv
// tick_stop_gen: free-running tick divider plus synchronised, debounced STOP button producing press pulses and a toggled stop level
//   ck        : board clock, rising edge
//   rs        : synchronous active-high reset
//   btn_stop  : raw asynchronous bouncy push-button, 1 = pressed
//   tick      : one-cycle pulse every DIV cycles
//   btn_clean : debounced button level
//   press     : one-cycle pulse on each debounced press
//   stop      : stop-mode level, toggles on every press
module tick_stop_gen #(
  parameter int DIV = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic ck,
  input  logic rs,
  input  logic btn_stop,
  output logic tick,
  output logic btn_clean,
  output logic press,
  output logic stop
);
  localparam int DW = $clog2(DIV);
  localparam int CW = $clog2(DB_CYCLES) + 1;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] db_cnt;
  logic sync1, sync2, btn_clean_d, div_wrap, db_done, rise;
  always_comb begin
    div_wrap = div_cnt == DW'(DIV - 1);
    db_done  = db_cnt == CW'(DB_CYCLES - 1);
    rise     = btn_clean & ~btn_clean_d;
  end
  always_ff @(posedge ck) begin
    if (rs) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      btn_clean_d <= 1'b0;
      press       <= 1'b0;
      div_cnt     <= '0;
      tick        <= 1'b0;
      stop        <= 1'b0;
    end else begin
      div_cnt     <= div_wrap ? '0 : div_cnt + 1'b1;
      tick        <= div_wrap;
      sync1       <= btn_stop;
      sync2       <= sync1;
      db_cnt      <= (sync2 == btn_clean || db_done) ? '0 : db_cnt + 1'b1;
      btn_clean   <= (sync2 != btn_clean && db_done) ? sync2 : btn_clean;
      btn_clean_d <= btn_clean;
      press       <= rise;
      stop        <= stop ^ rise;
    end
  end
endmodule

// File: tb/tb_tick_stop_gen.sv
// tb_tick_stop_gen: directed self-checking bench for tick_stop_gen with DIV=5, DB_CYCLES=4
module tb_tick_stop_gen;
  logic ck = 1'b0, rs = 1'b1, btn_stop = 1'b0;
  logic tick, btn_clean, press, stop;
  int checks = 0, failures = 0;
  tick_stop_gen #(.DIV(5), .DB_CYCLES(4)) dut (
    .ck(ck), .rs(rs), .btn_stop(btn_stop),
    .tick(tick), .btn_clean(btn_clean), .press(press), .stop(stop)
  );
  always #5 ck = ~ck;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic b);
    rs = r;
    btn_stop = b;
    @(posedge ck);
    #1;
  endtask
  initial begin
    int np;
    logic [7:0] bounce;
    for (int e = 1; e <= 3; e++) begin
      step(1'b1, 1'b0);
      chk($sformatf("t1_rst_e%0d", e), {28'd0, tick, btn_clean, press, stop}, 32'd0);
    end
    for (int e = 1; e <= 21; e++) begin
      step(1'b0, 1'b0);
      chk($sformatf("t1_tick_e%0d", e), tick, (e % 5) == 0);
    end
    step(1'b1, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      step(1'b0, 1'b1);
      chk($sformatf("t2_clean_e%0d", e), btn_clean, e >= 6);
      chk($sformatf("t2_press_e%0d", e), press, e == 7);
      chk($sformatf("t2_stop_e%0d", e), stop, e >= 7);
    end
    step(1'b1, 1'b0);
    bounce = 8'b0011_1011;
    for (int e = 1; e <= 16; e++) begin
      step(1'b0, e <= 8 ? bounce[8-e] : 1'b0);
      chk($sformatf("t3_out_e%0d", e), {29'd0, btn_clean, press, stop}, 32'd0);
    end
    np = 0;
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, (k <= 8) || (k >= 17 && k <= 24));
      np += int'(press);
      chk($sformatf("t4_press_k%0d", k), press, k == 7 || k == 23);
      chk($sformatf("t4_clean_k%0d", k), btn_clean, (k >= 6 && k < 14) || (k >= 22 && k < 30));
      chk($sformatf("t4_stop_k%0d", k), stop, k >= 7 && k < 23);
    end
    chk("t4_press_count", np, 2);
    step(1'b1, 1'b1);
    for (int e = 1; e <= 8; e++) step(1'b0, 1'b1);
    chk("t5_stop_before_rst", stop, 1'b1);
    step(1'b1, 1'b1);
    chk("t5_after_rst", {29'd0, btn_clean, press, stop}, 32'd0);
    for (int e = 1; e <= 9; e++) begin
      step(1'b0, 1'b1);
      chk($sformatf("t5_press_e%0d", e), press, e == 7);
      chk($sformatf("t5_stop_e%0d", e), stop, e >= 7);
    end
    step(1'b1, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, e >= 4);
      chk($sformatf("t6_tick_e%0d", e), tick, (e % 5) == 0);
      chk($sformatf("t6_press_e%0d", e), press, e == 10);
      chk($sformatf("t6_stop_e%0d", e), stop, e >= 10);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
